// File: rtl/npc_pc_unit.sv
// Next-PC generator and architectural PC register for the RV32I core.
// Misaligned targets and external faults redirect to TRAP_VEC.
module npc_pc_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int              IALIGN    = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall_i,
  input  logic [2:0]      npc_op_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic            trap_i,
  input  logic [3:0]      trap_cause_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] npc_o,
  output logic [XLEN-1:0] pc4_o,
  output logic            trap_taken_o,
  output logic [XLEN-1:0] epc_o,
  output logic [XLEN-1:0] badaddr_o,
  output logic [3:0]      cause_o
);

  localparam logic [2:0] OP_BR   = 3'd1;
  localparam logic [2:0] OP_JAL  = 3'd2;
  localparam logic [2:0] OP_JALR = 3'd3;
  localparam logic [2:0] OP_MRET = 3'd4;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] bad_q;
  logic [3:0]      cause_q;

  logic [XLEN-1:0] rel_sum;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] raw;
  logic            misal;
  logic            redirect;

  assign pc4_o    = pc_q + FOUR;
  assign rel_sum  = pc_q + imm_i;
  assign jalr_sum = rs1_i + imm_i;

  always_comb begin
    raw = pc4_o;
    unique case (1'b1)
      (npc_op_i == OP_BR):   raw = br_taken_i ? rel_sum : pc4_o;
      (npc_op_i == OP_JAL):  raw = rel_sum;
      (npc_op_i == OP_JALR): raw = {jalr_sum[XLEN-1:1], 1'b0};
      (npc_op_i == OP_MRET): raw = epc_q;
      default:               raw = pc4_o;
    endcase
  end

  // Only the 32-bit alignment build can see a bad target here.
  assign misal    = (IALIGN == 32) ? raw[1] : 1'b0;
  assign redirect = trap_i | misal;

  assign npc_o        = redirect ? TRAP_VEC : raw;
  assign trap_taken_o = !stall_i & redirect;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      bad_q   <= '0;
      cause_q <= 4'd0;
    end else if (!stall_i) begin
      pc_q <= npc_o;
      if (trap_i) begin
        epc_q   <= pc_q;
        cause_q <= trap_cause_i;
        bad_q   <= '0;
      end else if (misal) begin
        epc_q   <= pc_q;
        cause_q <= 4'd0;
        bad_q   <= raw;
      end
    end
  end

  assign pc_o      = pc_q;
  assign epc_o     = epc_q;
  assign badaddr_o = bad_q;
  assign cause_o   = cause_q;

endmodule

// File: tb/tb_npc_pc_unit.sv
// Bench for npc_pc_unit: directed table, corner sequences and a
// randomized run against a reference model, for IALIGN 32 and 16.
module tb_npc_pc_unit;

  typedef struct {
    logic        stall;
    logic [2:0]  op;
    logic        br;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        trap;
    logic [3:0]  cause;
  } in_t;

  typedef struct {
    logic        stall;
    logic [2:0]  op;
    logic        br;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        trap;
    logic [3:0]  cause;
    logic [31:0] pc4;
    logic [31:0] npc;
    logic        tt;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] bad;
    logic [3:0]  ecause;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] bad;
    logic [3:0]  cause;
  } mstate_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i;
  logic [2:0]  npc_op_i;
  logic        br_taken_i;
  logic [31:0] imm_i;
  logic [31:0] rs1_i;
  logic        trap_i;
  logic [3:0]  trap_cause_i;

  logic [31:0] pc_a, npc_a, pc4_a, epc_a, bad_a;
  logic        tt_a;
  logic [3:0]  cause_a;
  logic [31:0] pc_b, npc_b, pc4_b, epc_b, bad_b;
  logic        tt_b;
  logic [3:0]  cause_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  npc_pc_unit #(.IALIGN(32)) dut (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i),
    .npc_op_i(npc_op_i), .br_taken_i(br_taken_i),
    .imm_i(imm_i), .rs1_i(rs1_i), .trap_i(trap_i),
    .trap_cause_i(trap_cause_i), .pc_o(pc_a), .npc_o(npc_a),
    .pc4_o(pc4_a), .trap_taken_o(tt_a), .epc_o(epc_a),
    .badaddr_o(bad_a), .cause_o(cause_a)
  );

  npc_pc_unit #(.IALIGN(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i),
    .npc_op_i(npc_op_i), .br_taken_i(br_taken_i),
    .imm_i(imm_i), .rs1_i(rs1_i), .trap_i(trap_i),
    .trap_cause_i(trap_cause_i), .pc_o(pc_b), .npc_o(npc_b),
    .pc4_o(pc4_b), .trap_taken_o(tt_b), .epc_o(epc_b),
    .badaddr_o(bad_b), .cause_o(cause_b)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    stall_i      = v.stall;
    npc_op_i     = v.op;
    br_taken_i   = v.br;
    imm_i        = v.imm;
    rs1_i        = v.rs1;
    trap_i       = v.trap;
    trap_cause_i = v.cause;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input mstate_t s, input int ia,
                                input in_t v,
                                output logic [31:0] npc,
                                output logic tt,
                                output mstate_t ns);
    logic [31:0] t;
    logic        mis;
    case (v.op)
      3'd1:    t = v.br ? s.pc + v.imm : s.pc + 32'd4;
      3'd2:    t = s.pc + v.imm;
      3'd3:    t = ((v.rs1 + v.imm) / 32'd2) * 32'd2;
      3'd4:    t = s.epc;
      default: t = s.pc + 32'd4;
    endcase
    mis = (ia == 32) && ((t % 32'd4) != 32'd0);
    npc = (v.trap || mis) ? 32'h100 : t;
    tt  = !v.stall && (v.trap || mis);
    ns  = s;
    if (!v.stall) begin
      ns.pc = npc;
      if (v.trap) begin
        ns.epc = s.pc; ns.cause = v.cause; ns.bad = 32'd0;
      end else if (mis) begin
        ns.epc = s.pc; ns.cause = 4'd0; ns.bad = t;
      end
    end
  endfunction

  function automatic mstate_t mreset();
    mstate_t r;
    r.pc = 32'd0; r.epc = 32'd0; r.bad = 32'd0; r.cause = 4'd0;
    return r;
  endfunction

  vec_t    tbl [22];
  in_t     vi;
  mstate_t m32, m16, n32, n16;
  logic [31:0] e_npc32, e_npc16;
  logic        e_tt32, e_tt16;

  initial begin
    tbl[0]  = '{1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd3,
                32'h10, 32'h100, 1'b1, 32'h100, 32'hC, 32'h0, 4'd3};
    tbl[1]  = '{1'b0, 3'd1, 1'b0, 32'hFFFF_FFF0, 32'h0, 1'b0, 4'd0,
                32'h104, 32'h104, 1'b0, 32'h104, 32'hC, 32'h0, 4'd3};
    tbl[2]  = '{1'b0, 3'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 4'd0,
                32'h108, 32'h100, 1'b0, 32'h100, 32'hC, 32'h0, 4'd3};
    tbl[3]  = '{1'b0, 3'd1, 1'b1, 32'hFFFF_FFF0, 32'h0, 1'b0, 4'd0,
                32'h104, 32'hF0, 1'b0, 32'hF0, 32'hC, 32'h0, 4'd3};
    tbl[4]  = '{1'b0, 3'd2, 1'b0, 32'h110, 32'h0, 1'b0, 4'd0,
                32'hF4, 32'h200, 1'b0, 32'h200, 32'hC, 32'h0, 4'd3};
    tbl[5]  = '{1'b0, 3'd2, 1'b0, 32'h20, 32'h0, 1'b0, 4'd0,
                32'h204, 32'h220, 1'b0, 32'h220, 32'hC, 32'h0, 4'd3};
    tbl[6]  = '{1'b0, 3'd3, 1'b0, 32'h4, 32'h1001, 1'b0, 4'd0,
                32'h224, 32'h1004, 1'b0, 32'h1004, 32'hC, 32'h0, 4'd3};
    tbl[7]  = '{1'b0, 3'd3, 1'b0, 32'h0, 32'h1002, 1'b0, 4'd0,
                32'h1008, 32'h100, 1'b1, 32'h100, 32'h1004, 32'h1002, 4'd0};
    tbl[8]  = '{1'b0, 3'd2, 1'b0, 32'hFFFF_FF40, 32'h0, 1'b0, 4'd0,
                32'h104, 32'h40, 1'b0, 32'h40, 32'h1004, 32'h1002, 4'd0};
    tbl[9]  = '{1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd2,
                32'h44, 32'h100, 1'b1, 32'h100, 32'h40, 32'h0, 4'd2};
    tbl[10] = '{1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0,
                32'h104, 32'h104, 1'b0, 32'h104, 32'h40, 32'h0, 4'd2};
    tbl[11] = '{1'b0, 3'd4, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0,
                32'h108, 32'h40, 1'b0, 32'h40, 32'h40, 32'h0, 4'd2};
    tbl[12] = '{1'b0, 3'd2, 1'b0, 32'h6, 32'h0, 1'b0, 4'd0,
                32'h44, 32'h100, 1'b1, 32'h100, 32'h40, 32'h46, 4'd0};
    tbl[13] = '{1'b0, 3'd2, 1'b0, 32'h2, 32'h0, 1'b1, 4'd2,
                32'h104, 32'h100, 1'b1, 32'h100, 32'h100, 32'h0, 4'd2};
    tbl[14] = '{1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0,
                32'h104, 32'h104, 1'b0, 32'h104, 32'h100, 32'h0, 4'd2};
    tbl[15] = '{1'b0, 3'd4, 1'b0, 32'h0, 32'h0, 1'b1, 4'd7,
                32'h108, 32'h100, 1'b1, 32'h100, 32'h104, 32'h0, 4'd7};
    tbl[16] = '{1'b1, 3'd2, 1'b0, 32'h40, 32'h0, 1'b1, 4'd9,
                32'h104, 32'h100, 1'b0, 32'h100, 32'h104, 32'h0, 4'd7};
    tbl[17] = '{1'b1, 3'd2, 1'b0, 32'h40, 32'h0, 1'b0, 4'd0,
                32'h104, 32'h140, 1'b0, 32'h100, 32'h104, 32'h0, 4'd7};
    tbl[18] = '{1'b1, 3'd2, 1'b0, 32'h40, 32'h0, 1'b1, 4'd9,
                32'h104, 32'h100, 1'b0, 32'h100, 32'h104, 32'h0, 4'd7};
    tbl[19] = '{1'b0, 3'd2, 1'b0, 32'h40, 32'h0, 1'b0, 4'd0,
                32'h104, 32'h140, 1'b0, 32'h140, 32'h104, 32'h0, 4'd7};
    tbl[20] = '{1'b0, 3'd3, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 4'd0,
                32'h144, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'h104,
                32'h0, 4'd7};
    tbl[21] = '{1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0,
                32'h0, 32'h0, 1'b0, 32'h0, 32'h104, 32'h0, 4'd7};

    // Reset wins over stall and trap.
    reset_n = 1'b0;
    drive('{1'b1, 3'd2, 1'b0, 32'h8, 32'h0, 1'b1, 4'd5});
    tick(); tick();
    chk("rst pc", pc_a, 32'h0);
    chk("rst epc", epc_a, 32'h0);
    chk("rst bad", bad_a, 32'h0);
    chk("rst cause", {28'd0, cause_a}, 32'h0);
    reset_n = 1'b1;
    drive('{1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0});
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("seq pc", pc_a, 32'(4 * k));
    end

    for (int i = 0; i < 22; i++) begin
      vi = '{tbl[i].stall, tbl[i].op, tbl[i].br, tbl[i].imm,
             tbl[i].rs1, tbl[i].trap, tbl[i].cause};
      drive(vi);
      #1;
      chk($sformatf("row%0d pc4", i), pc4_a, tbl[i].pc4);
      chk($sformatf("row%0d npc", i), npc_a, tbl[i].npc);
      chk($sformatf("row%0d tt", i), {31'd0, tt_a}, {31'd0, tbl[i].tt});
      tick();
      chk($sformatf("row%0d pc", i), pc_a, tbl[i].pc);
      chk($sformatf("row%0d epc", i), epc_a, tbl[i].epc);
      chk($sformatf("row%0d bad", i), bad_a, tbl[i].bad);
      chk($sformatf("row%0d cause", i), {28'd0, cause_a},
          {28'd0, tbl[i].ecause});
    end

    // Reset during a pending trap redirect discards it.
    reset_n = 1'b0;
    drive('{1'b0, 3'd2, 1'b0, 32'h1002, 32'h0, 1'b1, 4'd4});
    tick();
    chk("midrst pc", pc_a, 32'h0);
    chk("midrst cause", {28'd0, cause_a}, 32'h0);
    reset_n = 1'b1;

    // JAL to 0x1002: traps in the 32-bit build, not in the 16-bit one.
    drive('{1'b0, 3'd2, 1'b0, 32'h1002, 32'h0, 1'b0, 4'd0});
    #1;
    chk("ia16 tt", {31'd0, tt_b}, 32'd0);
    chk("ia32 tt", {31'd0, tt_a}, 32'd1);
    tick();
    chk("ia16 pc", pc_b, 32'h1002);
    chk("ia16 bad", bad_b, 32'h0);
    chk("ia32 pc", pc_a, 32'h100);
    chk("ia32 bad", bad_a, 32'h1002);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m32 = mreset();
    m16 = mreset();
    for (int c = 0; c < 400; c++) begin
      vi.stall = ($urandom_range(0, 4) == 0);
      vi.op    = 3'($urandom_range(0, 7));
      vi.br    = 1'($urandom);
      vi.imm   = $urandom;
      if ($urandom_range(0, 1) == 1)
        vi.imm = {{20{vi.imm[11]}}, vi.imm[11:0]};
      vi.imm[0] = 1'b0;
      vi.rs1   = $urandom;
      vi.trap  = ($urandom_range(0, 7) == 0);
      vi.cause = 4'($urandom);
      reset_n  = ($urandom_range(0, 39) != 0);
      drive(vi);
      #1;
      model(m32, 32, vi, e_npc32, e_tt32, n32);
      model(m16, 16, vi, e_npc16, e_tt16, n16);
      chk("rnd pc4", pc4_a, m32.pc + 32'd4);
      chk("rnd npc", npc_a, e_npc32);
      chk("rnd tt", {31'd0, tt_a}, {31'd0, e_tt32});
      chk("rnd16 npc", npc_b, e_npc16);
      chk("rnd16 tt", {31'd0, tt_b}, {31'd0, e_tt16});
      tick();
      m32 = reset_n ? n32 : mreset();
      m16 = reset_n ? n16 : mreset();
      chk("rnd pc", pc_a, m32.pc);
      chk("rnd epc", epc_a, m32.epc);
      chk("rnd bad", bad_a, m32.bad);
      chk("rnd cause", {28'd0, cause_a}, {28'd0, m32.cause});
      chk("rnd16 pc", pc_b, m16.pc);
      chk("rnd16 epc", epc_b, m16.epc);
      chk("rnd16 bad", bad_b, m16.bad);
      chk("rnd16 cause", {28'd0, cause_b}, {28'd0, m16.cause});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
